// File: rtl/nav_pkg.sv
// Shared definitions for the line navigation sequencer.
// Contents:
//   - drive command encodings (identical to the drive block's decoder)
//   - per-node route actions stored in the route FIFO
//   - sequencer state enumeration
package nav_pkg;

  localparam logic [2:0] CMD_STOP  = 3'b000;
  localparam logic [2:0] CMD_FWD   = 3'b001;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;
  localparam logic [2:0] CMD_UTURN = 3'b100;

  localparam logic [1:0] ACT_STRAIGHT = 2'b00;
  localparam logic [1:0] ACT_LEFT     = 2'b01;
  localparam logic [1:0] ACT_RIGHT    = 2'b10;
  localparam logic [1:0] ACT_UTURN    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_CROSS,
    ST_TURN,
    ST_UTURN_REQ,
    ST_UTURN_WAIT,
    ST_FINISH,
    ST_LOST
  } nav_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Per-bit 2-FF synchronizer followed by a stability filter.
// A bit's stable value changes only after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset (stable value clears to 0)
//   raw_i     asynchronous input bits
//   stable_o  filtered bits, synchronous to clk
module sensor_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt_q [WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= RELOAD;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      // Down-counter restarts whenever the input agrees with the stable value,
      // so only an uninterrupted run of the new value gets through.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= RELOAD;
        end else if (cnt_q[i] == '0) begin
          stable_q[i] <= sync_q[i];
          cnt_q[i]    <= RELOAD;
        end else begin
          cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/line_nav_sequencer.sv
// Line-following navigation sequencer: converts three line sensors and a
// preloaded per-node route into cmd/base_speed for the drive block.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sensor          raw {left, centre, right} line sensors, 1 = on line
//   path_wr_en/data push a node action into the route FIFO
//   start           pulse: begin or resume navigation
//   robot_busy      drive block busy executing a U-turn
//   cmd, base_speed registered drive command and speed
//   path_full       route FIFO full
//   path_count      route entries stored
//   done            route exhausted at a node
//   lost            line lost or turn search timed out
//
// state          | meaning
// ---------------+-------------------------------------------------------
// ST_IDLE        | stopped after reset, waiting for start
// ST_FOLLOW      | tracking the line, watching for nodes and line loss
// ST_CROSS       | driving straight to carry the chassis over a node
// ST_TURN        | spinning until centre leaves then re-finds the line
// ST_UTURN_REQ   | requesting a U-turn until the drive block goes busy
// ST_UTURN_WAIT  | holding STOP until the drive block finishes the U-turn
// ST_FINISH      | route exhausted, done asserted, waiting for start
// ST_LOST        | error stop, lost asserted, waiting for start
module line_nav_sequencer
  import nav_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CROSS_TICKS     = 1_000_000,
  parameter int         LOST_TICKS      = 5_000_000,
  parameter int         TURN_TIMEOUT    = 40_000_000,
  parameter logic [7:0] SPEED_FWD       = 8'd200,
  parameter logic [7:0] SPEED_TURN      = 8'd140,
  parameter int         PATH_DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   sensor,
  input  logic                         path_wr_en,
  input  logic [1:0]                   path_wr_data,
  input  logic                         start,
  input  logic                         robot_busy,
  output logic [2:0]                   cmd,
  output logic [7:0]                   base_speed,
  output logic                         path_full,
  output logic [$clog2(PATH_DEPTH):0]  path_count,
  output logic                         done,
  output logic                         lost
);

  localparam int PW   = $clog2(PATH_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TMAX_A = (CROSS_TICKS > LOST_TICKS) ? CROSS_TICKS : LOST_TICKS;
  localparam int TMAX   = (TMAX_A > TURN_TIMEOUT) ? TMAX_A : TURN_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] CROSS_RELOAD = TW'(CROSS_TICKS - 1);
  localparam logic [TW-1:0] LOST_RELOAD  = TW'(LOST_TICKS - 1);
  localparam logic [TW-1:0] TURN_RELOAD  = TW'(TURN_TIMEOUT - 1);

  // ---------------- sensor conditioning ----------------
  logic [2:0] stable;

  sensor_debounce #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (sensor),
    .stable_o(stable)
  );

  logic armed_q, armed_d;
  logic node_ev;

  assign node_ev = armed_q && (stable == 3'b111);

  always_comb begin
    armed_d = armed_q;
    if (node_ev)                  armed_d = 1'b0;
    else if (stable != 3'b111)    armed_d = 1'b1;
  end

  // ---------------- route FIFO ----------------
  logic [1:0]      mem_q [PATH_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [1:0]      fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNTW'(PATH_DEPTH));
  // A write while full is dropped even if a pop happens in the same cycle.
  assign push       = path_wr_en && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= path_wr_data;
  end

  // ---------------- sequencer FSM ----------------
  nav_state_e     state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           timer_done;
  logic           phase_q, phase_d;           // TURN: 0 = wait centre off, 1 = wait centre on
  logic           cross_turn_q, cross_turn_d; // CROSS continues into TURN
  logic           turn_left_q, turn_left_d;
  logic [2:0]     cmd_q, cmd_d;
  logic [7:0]     speed_q, speed_d;
  logic           done_q, done_d;
  logic           lost_q, lost_d;

  assign timer_done = (timer_q == '0);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    phase_d      = phase_q;
    cross_turn_d = cross_turn_q;
    turn_left_d  = turn_left_q;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FOLLOW;
      end
      ST_FOLLOW: begin
        if (node_ev) begin
          if (fifo_empty) begin
            state_d = ST_FINISH;
          end else begin
            pop = 1'b1;
            case (fifo_head)
              ACT_STRAIGHT: begin
                state_d      = ST_CROSS;
                cross_turn_d = 1'b0;
              end
              ACT_LEFT: begin
                state_d      = ST_CROSS;
                cross_turn_d = 1'b1;
                turn_left_d  = 1'b1;
              end
              ACT_RIGHT: begin
                state_d      = ST_CROSS;
                cross_turn_d = 1'b1;
                turn_left_d  = 1'b0;
              end
              default: state_d = ST_UTURN_REQ;
            endcase
          end
        end else if (stable == 3'b000) begin
          if (timer_done) state_d = ST_LOST;
          else            timer_d = timer_q - TW'(1);
        end else begin
          // Line seen again: loss must be consecutive cycles of 000.
          timer_d = LOST_RELOAD;
        end
      end
      ST_CROSS: begin
        if (timer_done) state_d = cross_turn_q ? ST_TURN : ST_FOLLOW;
        else            timer_d = timer_q - TW'(1);
      end
      ST_TURN: begin
        if (phase_q && stable[1]) begin
          state_d = ST_FOLLOW;
        end else if (timer_done) begin
          state_d = ST_LOST;
        end else begin
          timer_d = timer_q - TW'(1);
          if (!stable[1]) phase_d = 1'b1;
        end
      end
      ST_UTURN_REQ: begin
        if (robot_busy) state_d = ST_UTURN_WAIT;
      end
      ST_UTURN_WAIT: begin
        // Only reachable with busy high, so any low level is the fall.
        if (!robot_busy) state_d = ST_FOLLOW;
      end
      ST_FINISH, ST_LOST: begin
        if (start) state_d = ST_FOLLOW;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state entry restarts the timer and the turn phase.
    if (state_d != state_q) begin
      phase_d = 1'b0;
      case (state_d)
        ST_CROSS: timer_d = CROSS_RELOAD;
        ST_TURN:  timer_d = TURN_RELOAD;
        default:  timer_d = LOST_RELOAD;
      endcase
    end
  end

  // Outputs are decided from the state being entered and registered.
  always_comb begin
    cmd_d   = cmd_q;
    speed_d = speed_q;
    case (state_d)
      ST_FOLLOW: begin
        case (stable)
          3'b010: begin
            cmd_d   = CMD_FWD;
            speed_d = SPEED_FWD;
          end
          3'b100, 3'b110: begin
            cmd_d   = CMD_LEFT;
            speed_d = SPEED_TURN;
          end
          3'b001, 3'b011: begin
            cmd_d   = CMD_RIGHT;
            speed_d = SPEED_TURN;
          end
          default: ; // 000, 101, 111: hold the last command
        endcase
      end
      ST_CROSS: begin
        cmd_d   = CMD_FWD;
        speed_d = SPEED_FWD;
      end
      ST_TURN: begin
        cmd_d   = turn_left_d ? CMD_LEFT : CMD_RIGHT;
        speed_d = SPEED_TURN;
      end
      ST_UTURN_REQ: begin
        cmd_d   = CMD_UTURN;
        speed_d = SPEED_TURN;
      end
      default: begin
        cmd_d   = CMD_STOP;
        speed_d = 8'd0;
      end
    endcase
    done_d = (state_d == ST_FINISH);
    lost_d = (state_d == ST_LOST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      phase_q      <= 1'b0;
      cross_turn_q <= 1'b0;
      turn_left_q  <= 1'b0;
      cmd_q        <= CMD_STOP;
      speed_q      <= 8'd0;
      done_q       <= 1'b0;
      lost_q       <= 1'b0;
      armed_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      cross_turn_q <= cross_turn_d;
      turn_left_q  <= turn_left_d;
      cmd_q        <= cmd_d;
      speed_q      <= speed_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
      armed_q      <= armed_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign cmd        = cmd_q;
  assign base_speed = speed_q;
  assign path_full  = fifo_full;
  assign path_count = count_q;
  assign done       = done_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_line_nav_sequencer.sv
// Self-checking bench for line_nav_sequencer with short timing parameters.
module tb_line_nav_sequencer;
  import nav_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sensor;
  logic       path_wr_en;
  logic [1:0] path_wr_data;
  logic       start;
  logic       robot_busy;
  logic [2:0] cmd;
  logic [7:0] base_speed;
  logic       path_full;
  logic [4:0] path_count;
  logic       done;
  logic       lost;

  line_nav_sequencer #(
    .DEBOUNCE_CYCLES(2),
    .CROSS_TICKS    (8),
    .LOST_TICKS     (20),
    .TURN_TIMEOUT   (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor      (sensor),
    .path_wr_en  (path_wr_en),
    .path_wr_data(path_wr_data),
    .start       (start),
    .robot_busy  (robot_busy),
    .cmd         (cmd),
    .base_speed  (base_speed),
    .path_full   (path_full),
    .path_count  (path_count),
    .done        (done),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [1:0] route_m [$];   // reference route queue

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cmd(input string tag, input logic [2:0] exp, input int lim);
    int n = 0;
    while (cmd !== exp && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cmd), 32'(exp));
  endtask

  // which: 0 = done, 1 = lost
  task automatic wait_flag(input string tag, input int which, input int lim);
    int n = 0;
    while (((which == 0) ? done : lost) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'((which == 0) ? done : lost), 32'd1);
  endtask

  task automatic push_route(input logic [1:0] act);
    path_wr_en   = 1'b1;
    path_wr_data = act;
    if (route_m.size() < 16) route_m.push_back(act);
    tick(1);
    path_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_cmd;
    logic [7:0] exp_spd;
    logic [2:0] pat, prev_pat;
    logic [2:0] pats [7];
    int n;

    rst = 1'b1; sensor = 3'b000; path_wr_en = 1'b0; path_wr_data = 2'b00;
    start = 1'b0; robot_busy = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_cmd",   32'(cmd), 32'(CMD_STOP));
    check("rst_speed", 32'(base_speed), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_lost",  32'(lost), 32'd0);
    check("rst_count", 32'(path_count), 32'd0);
    check("rst_full",  32'(path_full), 32'd0);

    // Fill the FIFO, then one more write that must be dropped.
    for (int i = 0; i < 16; i++) push_route(2'($urandom_range(3)));
    check("fill_count", 32'(path_count), 32'(route_m.size()));
    check("fill_full",  32'(path_full), 32'd1);
    push_route(2'b01);
    check("overflow_count", 32'(path_count), 32'd16);

    // Asynchronous reset empties the FIFO without a clock edge.
    #2 rst = 1'b1;
    #1 check("async_rst_count", 32'(path_count), 32'd0);
    route_m.delete();
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Basic following.
    push_route(ACT_LEFT);
    check("load_count", 32'(path_count), 32'd1);
    sensor = 3'b010;
    pulse_start();
    wait_cmd("follow_fwd", CMD_FWD, 4);
    check("follow_fwd_speed", 32'(base_speed), 32'd200);
    sensor = 3'b100;
    wait_cmd("follow_left", CMD_LEFT, 5);
    check("follow_left_speed", 32'(base_speed), 32'd140);

    // Node with a left turn queued: 8 cycles of FWD, then LEFT.
    sensor = 3'b111;
    wait_cmd("cross_start", CMD_FWD, 6);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cmd === CMD_FWD) n++;
      else break;
    end
    check("cross_len", 32'(n), 32'd8);
    check("turn_cmd", 32'(cmd), 32'(CMD_LEFT));
    void'(route_m.pop_front());
    check("turn_pop_count", 32'(path_count), 32'(route_m.size()));
    sensor = 3'b000;
    tick(8);
    check("turn_phase_b_cmd", 32'(cmd), 32'(CMD_LEFT));
    sensor = 3'b010;
    wait_cmd("turn_exit_fwd", CMD_FWD, 6);

    // U-turn handshake.
    push_route(ACT_UTURN);
    check("uturn_count", 32'(path_count), 32'd1);
    sensor = 3'b111;
    wait_cmd("uturn_req", CMD_UTURN, 6);
    tick(5);
    check("uturn_hold", 32'(cmd), 32'(CMD_UTURN));
    check("uturn_speed", 32'(base_speed), 32'd140);
    robot_busy = 1'b1;
    tick(2);
    check("uturn_wait_stop", 32'(cmd), 32'(CMD_STOP));
    sensor = 3'b010;
    tick(8);
    check("uturn_wait_hold", 32'(cmd), 32'(CMD_STOP));
    robot_busy = 1'b0;
    wait_cmd("uturn_resume", CMD_FWD, 3);
    void'(route_m.pop_front());
    check("uturn_pop_count", 32'(path_count), 32'(route_m.size()));

    // Node with an empty route finishes.
    sensor = 3'b111;
    wait_flag("finish_done", 0, 6);
    check("finish_cmd",   32'(cmd), 32'(CMD_STOP));
    check("finish_speed", 32'(base_speed), 32'd0);
    pulse_start();
    check("finish_restart_done", 32'(done), 32'd0);
    sensor = 3'b010;
    wait_cmd("finish_resume", CMD_FWD, 6);

    // Line loss after 20 consecutive cycles of 000 (plus sync/filter delay).
    push_route(ACT_RIGHT);
    sensor = 3'b000;
    tick(20);
    check("lost_early", 32'(lost), 32'd0);
    wait_flag("lost_set", 1, 10);
    check("lost_cmd",   32'(cmd), 32'(CMD_STOP));
    check("lost_speed", 32'(base_speed), 32'd0);
    check("lost_keeps_fifo", 32'(path_count), 32'(route_m.size()));

    // Resume, then a right turn whose centre never drops: timeout after 50.
    sensor = 3'b010;
    pulse_start();
    check("lost_cleared", 32'(lost), 32'd0);
    wait_cmd("resume_fwd", CMD_FWD, 6);
    sensor = 3'b111;
    wait_cmd("turn_right", CMD_RIGHT, 20);
    void'(route_m.pop_front());
    n = 0;
    while (lost !== 1'b1 && n < 70) begin
      tick(1);
      n++;
    end
    check("turn_timeout_len", 32'(n), 32'd50);
    check("turn_timeout_cmd", 32'(cmd), 32'(CMD_STOP));

    // Randomized following against the sensor-to-command rules.
    pats[0] = 3'b010; pats[1] = 3'b100; pats[2] = 3'b110; pats[3] = 3'b001;
    pats[4] = 3'b011; pats[5] = 3'b101; pats[6] = 3'b000;
    exp_cmd = CMD_STOP;
    exp_spd = 8'd0;
    prev_pat = 3'b111;
    pat = pats[$urandom_range(6)];
    sensor = pat;
    pulse_start();
    for (int it = 0; it < 14; it++) begin
      if (it > 0) begin
        pat = pats[$urandom_range(6)];
        if (pat == 3'b000 && prev_pat == 3'b000) pat = 3'b010;
        sensor = pat;
        if ($urandom_range(1) == 1) push_route(2'($urandom_range(3)));
        else tick(1);
      end
      tick(9);
      case (pat)
        3'b010:         begin exp_cmd = CMD_FWD;   exp_spd = 8'd200; end
        3'b100, 3'b110: begin exp_cmd = CMD_LEFT;  exp_spd = 8'd140; end
        3'b001, 3'b011: begin exp_cmd = CMD_RIGHT; exp_spd = 8'd140; end
        default: ;
      endcase
      check("rand_cmd",   32'(cmd), 32'(exp_cmd));
      check("rand_speed", 32'(base_speed), 32'(exp_spd));
      check("rand_count", 32'(path_count), 32'(route_m.size()));
      check("rand_full",  32'(path_full), 32'(route_m.size() == 16));
      prev_pat = pat;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_nav_sequencer.md
Name: line_nav_sequencer

Overview:
- Upstream command source for robot_drive_system: turns three line sensors plus a preloaded per-node route into the drive block's cmd/base_speed.
- Contains a small route FIFO and a follow/turn state machine.
- Handshakes U-turns through the drive block's robot_busy.

Parameters:
- DEBOUNCE_CYCLES, 4, cycles a synchronized sensor bit must be stable before it is accepted.
- CROSS_TICKS, 1_000_000, cycles of FWD used to carry the chassis over a node.
- LOST_TICKS, 5_000_000, cycles of sensor 000 before declaring the line lost.
- TURN_TIMEOUT, 40_000_000, maximum cycles in a turn search.
- SPEED_FWD, 8'd200, base_speed while driving straight.
- SPEED_TURN, 8'd140, base_speed for corrections and turns.
- PATH_DEPTH, 16, route FIFO entries (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sensor  in  3  raw line sensors {left, centre, right}; 1 = on line; asynchronous to clk
- path_wr_en  in  1  push path_wr_data into the route FIFO
- path_wr_data  in  2  node action: 00 straight, 01 left, 10 right, 11 U-turn
- start  in  1  one-cycle pulse; begins or resumes navigation
- robot_busy  in  1  from drive block; high while a U-turn executes
- cmd  out  3  to drive block: 000 STOP, 001 FWD, 010 LEFT, 011 RIGHT, 100 UTURN
- base_speed  out  8  to drive block
- path_full  out  1  route FIFO holds PATH_DEPTH entries
- path_count  out  $clog2(PATH_DEPTH)+1  entries stored
- done  out  1  route exhausted at a node
- lost  out  1  line-lost or turn-timeout error

Behaviour:
- Reset: cmd=000, base_speed=0, done=0, lost=0, FIFO emptied (path_count=0, path_full=0), state IDLE, node detector armed.
- Sensor path, per bit: 2-FF synchronizer, then a filter that updates the stable value once the input has held for DEBOUNCE_CYCLES.
- cmd and base_speed are registered: one cycle after the state/decision that produces them.
- FIFO:
  - A write when full is dropped; count is unchanged.
  - A simultaneous write and pop both take effect; count is unchanged.
  - Pointers wrap modulo PATH_DEPTH.
  - Writes are accepted in every state.
- Node event: stable sensor == 111 while armed. The event disarms the detector; it re-arms when stable sensor != 111.
- States:
  - IDLE: cmd STOP, speed 0. start -> FOLLOW.
  - FOLLOW, mapping from stable sensor:
    - 010 -> FWD / SPEED_FWD.
    - 100 or 110 -> LEFT / SPEED_TURN.
    - 001 or 011 -> RIGHT / SPEED_TURN.
    - 101 -> keep last cmd.
    - 000 -> keep last cmd; after LOST_TICKS consecutive cycles -> LOST.
    - Node event with FIFO empty -> FINISH.
    - Node event otherwise: pop the entry. Straight -> CROSS; left/right -> CROSS then TURN; U-turn -> UTURN_REQ.
  - CROSS: FWD / SPEED_FWD for CROSS_TICKS, then FOLLOW (straight) or TURN (left/right).
  - TURN:
    - Drives LEFT or RIGHT / SPEED_TURN.
    - Phase A waits for centre==0; phase B waits for centre==1, then -> FOLLOW.
    - Exceeding TURN_TIMEOUT total -> LOST.
  - UTURN_REQ: cmd UTURN / SPEED_TURN held until robot_busy==1, then -> UTURN_WAIT.
  - UTURN_WAIT:
    - cmd STOP (prevents the drive block re-entering its U-turn when it returns to IDLE).
    - robot_busy falling -> FOLLOW.
    - robot_busy already low on entry counts as a fall.
  - FINISH: cmd STOP, speed 0, done=1. start -> FOLLOW, clearing done.
  - LOST: cmd STOP, speed 0, lost=1. start -> FOLLOW, clearing lost. FIFO contents are kept.
- start is ignored in every other state.
- Timers reset on every state entry; timer widths cover their parameter.
- rst mid-operation returns to reset values immediately, including the FIFO.

Decomposition:
- Shared package nav_pkg:
  - cmd encodings identical to the drive block (CMD_STOP..CMD_UTURN);
  - node action encodings;
  - state enum.
- One sub-module, sensor_debounce (width-parameterised synchronizer + stability filter), instantiated once for all three bits.
- FIFO stays inline.

Test Plan (bench overrides DEBOUNCE_CYCLES=2, CROSS_TICKS=8, LOST_TICKS=20, TURN_TIMEOUT=50):
- Reset -> cmd=000, base_speed=0, done=0, lost=0, path_count=0. Then write 16 entries -> path_full=1; a 17th write leaves path_count=16.
- Load {01}, start, sensor=010 -> cmd=001, speed=200 within sync+debounce+1 cycles. sensor=100 -> cmd=010, speed=140.
- Sensor=111 with left queued:
  - expect cmd=001 for 8 cycles, then cmd=010;
  - drive centre 0 then 1 -> back to FOLLOW;
  - path_count decremented by 1.
- U-turn entry at node:
  - cmd=100 held while robot_busy=0;
  - robot_busy=1 -> cmd=000;
  - robot_busy=0 -> FOLLOW with cmd set by sensor.
- Node with empty FIFO -> cmd=000, done=1. start -> done=0, FOLLOW.
- sensor=000 for 20 cycles in FOLLOW -> lost=1, cmd=000. Turn with centre never dropping -> lost=1 after 50 cycles.
